multi_tone_nco_bank: RTL

//  Parametrised test-tone source for the FIR audio chain. Runs NUM_CH phase accumulators

---
 rtl/multi_tone_nco_bank_if.sv | 30 +++
 rtl/multi_tone_nco_bank.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multi_tone_nco_bank_if.sv
// Config and sample bus of the tone bank: the master side drives config, the slave side
// (the tone bank) drives the sample stream and status flags.
interface multi_tone_nco_bank_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int CH_AW = 2
);
    logic [31:0]             div_period;
    logic                    cfg_we;
    logic [CH_AW-1:0]        cfg_ch;
    logic [ACC_W-1:0]        cfg_inc;
    logic [1:0]              cfg_mode;
    logic [2:0]              cfg_shift;
    logic                    cfg_clr_phase;
    logic                    sample_tick;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;
    logic                    busy;
    logic                    overrun;

    modport master (
        output div_period, cfg_we, cfg_ch, cfg_inc, cfg_mode, cfg_shift, cfg_clr_phase,
        input  sample_tick, sample_out, sample_valid, busy, overrun
    );

    modport slave (
        input  div_period, cfg_we, cfg_ch, cfg_inc, cfg_mode, cfg_shift, cfg_clr_phase,
        output sample_tick, sample_out, sample_valid, busy, overrun
    );
endinterface

// File: rtl/multi_tone_nco_bank.sv
// NUM_CH time-multiplexed NCO tones mixed into one saturated sample per divider strobe.
// Latency: sample_valid NUM_CH+1 clks after sample_tick; no backpressure, ticks while busy are dropped and flag overrun.
module multi_tone_nco_bank #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int CH_AW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_tone_nco_bank_if.slave bus
);
    localparam int SUM_W = OUT_W + CH_AW;
    localparam logic [31:0] MIN_P = 32'(NUM_CH + 2);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [OUT_W-1:0] SQ_POS  = OUT_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [OUT_W-1:0] SQ_NEG  = -SQ_POS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [31:0]             per_q, per_d;
    logic [CH_AW-1:0]        ch_q, ch_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    overrun_q, overrun_d;
    logic [ACC_W-1:0]        phase_q [NUM_CH];
    logic [ACC_W-1:0]        phase_d [NUM_CH];
    logic [ACC_W-1:0]        inc_q   [NUM_CH];
    logic [ACC_W-1:0]        inc_d   [NUM_CH];
    logic [1:0]              mode_q  [NUM_CH];
    logic [1:0]              mode_d  [NUM_CH];
    logic [2:0]              shift_q [NUM_CH];
    logic [2:0]              shift_d [NUM_CH];

    logic                    tick;
    logic                    cfg_ok;
    logic [ACC_W-1:0]        p;
    logic [OUT_W-1:0]        t;
    logic [OUT_W-1:0]        u;
    logic signed [OUT_W-1:0] wave;
    logic signed [OUT_W-1:0] wave_sh;
    logic signed [SUM_W-1:0] acc;

    generate
        if (NUM_CH == (1 << CH_AW)) begin : g_full_range
            assign cfg_ok = 1'b1;
        end else begin : g_part_range
            assign cfg_ok = (32'(bus.cfg_ch) < 32'(NUM_CH));
        end
    endgenerate

    // The period is sampled when the counter restarts, so a new div_period lands at the wrap.
    always_comb begin
        per_d = per_q;
        if (cnt_q == '0) begin
            per_d = (bus.div_period < MIN_P) ? MIN_P : bus.div_period;
        end
        tick  = (cnt_q == per_d - 32'd1);
        cnt_d = tick ? '0 : cnt_q + 32'd1;
    end

    always_comb begin
        p = phase_q[ch_q] + inc_q[ch_q];
        t = p[ACC_W-1 -: OUT_W];
        u = p[ACC_W-2 -: OUT_W] ^ {OUT_W{p[ACC_W-1]}};
        case (mode_q[ch_q])
            2'd0:    wave = {~t[OUT_W-1], t[OUT_W-2:0]};
            2'd1:    wave = p[ACC_W-1] ? SQ_NEG : SQ_POS;
            2'd2:    wave = {~u[OUT_W-1], u[OUT_W-2:0]};
            default: wave = '0;
        endcase
        wave_sh = wave >>> shift_q[ch_q];
        acc     = sum_q + SUM_W'(wave_sh);
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        sum_d     = sum_q;
        out_d     = out_q;
        overrun_d = overrun_q;
        phase_d   = phase_q;
        inc_d     = inc_q;
        mode_d    = mode_q;
        shift_d   = shift_q;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_RUN;
                    ch_d    = '0;
                    sum_d   = '0;
                end
            end
            S_RUN: begin
                phase_d[ch_q] = p;
                sum_d         = acc;
                ch_d          = ch_q + 1'b1;
                if (32'(ch_q) == 32'(NUM_CH - 1)) begin
                    state_d = S_DONE;
                    if (acc > SAT_MAX)      out_d = SAT_MAX[OUT_W-1:0];
                    else if (acc < SAT_MIN) out_d = SAT_MIN[OUT_W-1:0];
                    else                    out_d = acc[OUT_W-1:0];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;

        // Config lands after the RUN update above, so a same-cycle hit still uses the old values.
        if (bus.cfg_we && cfg_ok) begin
            inc_d[bus.cfg_ch]   = bus.cfg_inc;
            mode_d[bus.cfg_ch]  = bus.cfg_mode;
            shift_d[bus.cfg_ch] = bus.cfg_shift;
            if (bus.cfg_clr_phase) phase_d[bus.cfg_ch] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_q     <= MIN_P;
            ch_q      <= '0;
            sum_q     <= '0;
            out_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                mode_q[i]  <= 2'd3;
                shift_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            ch_q      <= ch_d;
            sum_q     <= sum_d;
            out_q     <= out_d;
            overrun_q <= overrun_d;
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            mode_q    <= mode_d;
            shift_q   <= shift_d;
        end
    end

    assign bus.sample_tick  = tick;
    assign bus.sample_out   = out_q;
    assign bus.sample_valid = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.overrun      = overrun_q;
endmodule
